// File: rtl/p2s_pkg.sv
// Shared definitions for the parallel-to-serial transmitter.
// Holds the transmitter state encoding used by the top-level FSM.
package p2s_pkg;

    typedef enum logic {
        P2S_IDLE  = 1'b0,
        P2S_SHIFT = 1'b1
    } p2s_state_e;

endpackage

// File: rtl/parallel_to_serial_if.sv
// Handshake bundle for the parallel-to-serial transmitter.
//   parallel_valid/parallel_ready/parallel_data : word input handshake
//   serial_valid/serial_ready/serial_data       : bit output handshake
//   serial_last                                 : current bit is the word's MSB
//   busy                                        : a word is shifting or held
// slave  = transmitter view, master = upstream/downstream (bench) view.
interface parallel_to_serial_if #(
    parameter int unsigned width = 8
);

    logic             parallel_valid;
    logic             parallel_ready;
    logic [width-1:0] parallel_data;
    logic             serial_valid;
    logic             serial_ready;
    logic             serial_data;
    logic             serial_last;
    logic             busy;

    modport slave (
        input  parallel_valid, parallel_data, serial_ready,
        output parallel_ready, serial_valid, serial_data, serial_last, busy
    );

    modport master (
        output parallel_valid, parallel_data, serial_ready,
        input  parallel_ready, serial_valid, serial_data, serial_last, busy
    );

endinterface

// File: rtl/p2s_hold_buffer.sv
// One-entry holding register for the parallel-to-serial transmitter.
// Ports:
//   clk, rst     : clock, asynchronous active-low reset
//   load         : capture load_data, mark valid
//   pop          : release the held word (clear valid)
//   load_data    : word to hold
//   hold_valid   : buffer holds a word
//   hold_data    : held word
module p2s_hold_buffer #(
    parameter int unsigned width = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             pop,
    input  logic [width-1:0] load_data,
    output logic             hold_valid,
    output logic [width-1:0] hold_data
);

    logic             valid_q, valid_d;
    logic [width-1:0] data_q,  data_d;

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (pop) begin
            valid_d = 1'b0;
        end
        if (load) begin
            valid_d = 1'b1;
            data_d  = load_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign hold_valid = valid_q;
    assign hold_data  = data_q;

endmodule

// File: rtl/parallel_to_serial.sv
// Parallel-to-serial transmitter: accepts a width-bit word over a valid/ready
// handshake and emits it LSB first, one bit per accepted serial cycle.
// A one-entry hold buffer lets the next word be taken while shifting, so
// back-to-back words stream without a bubble.
// Ports:
//   clk  : rising-edge clock
//   rst  : asynchronous active-low reset
//   bus  : parallel_to_serial_if.slave (word in, bit out, serial_last, busy)
module parallel_to_serial
    import p2s_pkg::*;
#(
    parameter int unsigned width = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    parallel_to_serial_if.slave        bus
);

    localparam int unsigned CW = $clog2(width);
    localparam logic [CW-1:0] LAST_CNT = CW'(width - 1);

    p2s_state_e       state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [width-1:0] shreg_q, shreg_d;
    logic             serial_valid_q, serial_valid_d;

    logic             hold_valid;
    logic [width-1:0] hold_data;
    logic             hold_load;
    logic             hold_pop;

    logic             in_xfer;
    logic             out_xfer;
    logic             last_bit;

    assign in_xfer  = bus.parallel_valid & ~hold_valid;
    assign out_xfer = serial_valid_q & bus.serial_ready;
    assign last_bit = (cnt_q == LAST_CNT);

    p2s_hold_buffer #(
        .width (width)
    ) u_hold (
        .clk        (clk),
        .rst        (rst),
        .load       (hold_load),
        .pop        (hold_pop),
        .load_data  (bus.parallel_data),
        .hold_valid (hold_valid),
        .hold_data  (hold_data)
    );

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        shreg_d   = shreg_q;
        hold_load = 1'b0;
        hold_pop  = 1'b0;

        case (state_q)
            P2S_IDLE: begin
                if (in_xfer) begin
                    shreg_d = bus.parallel_data;
                    cnt_d   = '0;
                    state_d = P2S_SHIFT;
                end
            end
            P2S_SHIFT: begin
                if (out_xfer && last_bit) begin
                    // Word boundary: the held word has priority; a word arriving
                    // now with the hold empty bypasses the buffer entirely.
                    cnt_d = '0;
                    if (hold_valid) begin
                        shreg_d  = hold_data;
                        hold_pop = 1'b1;
                    end else if (in_xfer) begin
                        shreg_d = bus.parallel_data;
                    end else begin
                        shreg_d = '0;
                        state_d = P2S_IDLE;
                    end
                end else begin
                    if (out_xfer) begin
                        shreg_d = shreg_q >> 1;
                        cnt_d   = cnt_q + CW'(1);
                    end
                    hold_load = in_xfer;
                end
            end
            default: state_d = P2S_IDLE;
        endcase

        serial_valid_d = (state_d == P2S_SHIFT);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q        <= P2S_IDLE;
            cnt_q          <= '0;
            shreg_q        <= '0;
            serial_valid_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            shreg_q        <= shreg_d;
            serial_valid_q <= serial_valid_d;
        end
    end

    assign bus.parallel_ready = ~hold_valid;
    assign bus.serial_valid   = serial_valid_q;
    assign bus.serial_data    = shreg_q[0];
    assign bus.serial_last    = last_bit & serial_valid_q;
    assign bus.busy           = (state_q == P2S_SHIFT) | hold_valid;

endmodule

// File: tb/tb_parallel_to_serial.sv
// Self-checking bench for parallel_to_serial (width = 8).
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_parallel_to_serial;

    localparam int unsigned W = 8;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    parallel_to_serial_if #(.width(W)) bif ();

    parallel_to_serial #(.width(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bif)
    );

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [7:0] word;
        string      bits;   // expected serial order, first transmitted bit first
    } vec_t;

    vec_t vt[8];
    vec_t sq[4];

    // Receiver model: collects bits LSB first, emits a word on serial_last.
    logic [7:0] rx_sh;
    int         rx_cnt;
    logic [7:0] rx_q[$];
    int         rx_cnt_q[$];

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_sh  <= '0;
            rx_cnt <= 0;
        end else if (bif.serial_valid && bif.serial_ready) begin
            rx_sh <= {bif.serial_data, rx_sh[7:1]};
            if (bif.serial_last) begin
                rx_q.push_back({bif.serial_data, rx_sh[7:1]});
                rx_cnt_q.push_back(rx_cnt);
                rx_cnt <= 0;
            end else begin
                rx_cnt <= rx_cnt + 1;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    function automatic logic bit_of(input string s, input int i);
        return (s[i] == "1");
    endfunction

    task automatic check_idle(input string tag);
        chk({tag, "_valid"}, 32'(bif.serial_valid), 0);
        chk({tag, "_data"},  32'(bif.serial_data), 0);
        chk({tag, "_last"},  32'(bif.serial_last), 0);
        chk({tag, "_busy"},  32'(bif.busy), 0);
        chk({tag, "_pready"}, 32'(bif.parallel_ready), 1);
    endtask

    // One word with serial_ready held high; checks every bit and the return to idle.
    task automatic send_single(input vec_t v);
        int n;
        n = 0;
        bif.serial_ready = 1'b1;
        while (!bif.parallel_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("single_pready", 32'(bif.parallel_ready), 1);
        bif.parallel_valid = 1'b1;
        bif.parallel_data  = v.word;
        @(negedge clk);
        bif.parallel_valid = 1'b0;
        bif.parallel_data  = 8'($urandom);
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("single_%h_valid%0d", v.word, i), 32'(bif.serial_valid), 1);
            chk($sformatf("single_%h_data%0d", v.word, i), 32'(bif.serial_data), 32'(bit_of(v.bits, i)));
            chk($sformatf("single_%h_last%0d", v.word, i), 32'(bif.serial_last), (i == 7) ? 1 : 0);
            @(negedge clk);
        end
        chk("single_end_valid", 32'(bif.serial_valid), 0);
        chk("single_end_busy", 32'(bif.busy), 0);
    endtask

    // Stream sq[0..n-1] with upstream always valid; bp selects the 1,0,0,1 ready pattern.
    task automatic run_stream(input string tag, input int n, input bit bp);
        int   idx, k, cyc;
        bit   started, pr_low, stalled, fire_prev, pr_prev;
        logic d_prev, l_prev;
        idx = 0; k = 0; cyc = 0;
        started = 0; pr_low = 0; stalled = 0;
        d_prev = 0; l_prev = 0;
        bif.parallel_valid = 1'b1;
        bif.parallel_data  = sq[0].word;
        fire_prev = bif.parallel_ready;
        pr_prev   = bif.parallel_ready;
        @(negedge clk);
        while (k < n * 8 && cyc < 300) begin
            bif.serial_ready = bp ? ((cyc % 4) == 0 || (cyc % 4) == 3) : 1'b1;
            if (bif.serial_valid) started = 1;
            if (!bp && started) chk({tag, "_no_gap"}, 32'(bif.serial_valid), 1);
            if (!bif.parallel_ready) pr_low = 1;
            if (!pr_prev && bif.parallel_ready) chk({tag, "_pop_at_boundary"}, 32'(k % 8), 0);
            pr_prev = bif.parallel_ready;
            if (bif.serial_valid) begin
                if (stalled) begin
                    chk({tag, "_stall_data"}, 32'(bif.serial_data), 32'(d_prev));
                    chk({tag, "_stall_last"}, 32'(bif.serial_last), 32'(l_prev));
                end
                if (bif.serial_ready) begin
                    chk($sformatf("%s_bit%0d", tag, k), 32'(bif.serial_data), 32'(bit_of(sq[k / 8].bits, k % 8)));
                    chk($sformatf("%s_last%0d", tag, k), 32'(bif.serial_last), ((k % 8) == 7) ? 1 : 0);
                    k++;
                    stalled = 0;
                end else begin
                    stalled = 1;
                    d_prev  = bif.serial_data;
                    l_prev  = bif.serial_last;
                end
            end
            if (fire_prev) idx++;
            bif.parallel_valid = (idx < n);
            if (idx < n) bif.parallel_data = sq[idx].word;
            fire_prev = bif.parallel_valid && bif.parallel_ready;
            cyc++;
            @(negedge clk);
        end
        if (fire_prev) idx++;
        bif.parallel_valid = 1'b0;
        bif.serial_ready   = 1'b1;
        chk({tag, "_bit_count"}, 32'(k), 32'(n * 8));
        chk({tag, "_words_taken"}, 32'(idx), 32'(n));
        chk({tag, "_hold_used"}, 32'(pr_low), 1);
        chk({tag, "_end_valid"}, 32'(bif.serial_valid), 0);
        chk({tag, "_end_busy"}, 32'(bif.busy), 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int   n;
        logic [7:0] tx[16];
        int   idx, cyc;
        bit   fire_prev;

        vt[0] = '{8'hA5, "10100101"};
        vt[1] = '{8'h5A, "01011010"};
        vt[2] = '{8'h96, "01101001"};
        vt[3] = '{8'h01, "10000000"};
        vt[4] = '{8'hFF, "11111111"};
        vt[5] = '{8'h3C, "00111100"};
        vt[6] = '{8'hC3, "11000011"};
        vt[7] = '{8'h0F, "11110000"};

        rst = 1'b0;
        bif.parallel_valid = 1'b0;
        bif.parallel_data  = '0;
        bif.serial_ready   = 1'b0;
        #2;
        check_idle("reset");
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_idle("post_reset");

        // Single words from the table.
        for (int i = 0; i < 3; i++) send_single(vt[i]);

        // Back-to-back 01, FF, 3C.
        sq[0] = vt[3]; sq[1] = vt[4]; sq[2] = vt[5];
        run_stream("b2b", 3, 1'b0);

        // Backpressure on C3 with a second word (5A) filling the hold buffer.
        sq[0] = vt[6]; sq[1] = vt[1];
        run_stream("bp", 2, 1'b1);

        // Last bit of A5 consumed in the same cycle a new word (3C) arrives.
        bif.serial_ready   = 1'b1;
        bif.parallel_valid = 1'b1;
        bif.parallel_data  = 8'hA5;
        @(negedge clk);
        bif.parallel_valid = 1'b0;
        n = 0;
        while (!bif.serial_last && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("bypass_last_seen", 32'(bif.serial_last), 1);
        chk("bypass_pready", 32'(bif.parallel_ready), 1);
        bif.parallel_valid = 1'b1;
        bif.parallel_data  = 8'h3C;
        @(negedge clk);
        bif.parallel_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("bypass_valid%0d", i), 32'(bif.serial_valid), 1);
            chk($sformatf("bypass_data%0d", i), 32'(bif.serial_data), 32'(bit_of(vt[5].bits, i)));
            chk($sformatf("bypass_last%0d", i), 32'(bif.serial_last), (i == 7) ? 1 : 0);
            chk($sformatf("bypass_no_hold%0d", i), 32'(bif.parallel_ready), 1);
            @(negedge clk);
        end
        chk("bypass_end_valid", 32'(bif.serial_valid), 0);

        // Reset mid-word: 96 shifting, FF held, reset after 3 bits.
        bif.parallel_valid = 1'b1;
        bif.parallel_data  = 8'h96;
        @(negedge clk);
        bif.parallel_data  = 8'hFF;
        @(negedge clk);
        bif.parallel_valid = 1'b0;
        chk("rst_hold_full", 32'(bif.parallel_ready), 0);
        @(negedge clk);
        @(negedge clk);
        chk("rst_pre_valid", 32'(bif.serial_valid), 1);
        chk("rst_pre_data", 32'(bif.serial_data), 32'(bit_of(vt[2].bits, 3)));
        #2;
        rst = 1'b0;
        #1;
        check_idle("rst_async");
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk($sformatf("rst_no_partial%0d", i), 32'(bif.serial_valid), 0);
        end
        send_single(vt[7]);

        // Loopback through the receiver model with random words and random ready.
        rx_q.delete();
        rx_cnt_q.delete();
        for (int i = 0; i < 16; i++) tx[i] = 8'($urandom);
        idx = 0;
        cyc = 0;
        bif.parallel_valid = 1'b1;
        bif.parallel_data  = tx[0];
        fire_prev = bif.parallel_ready;
        while (rx_q.size() < 16 && cyc < 3000) begin
            @(negedge clk);
            if (fire_prev) idx++;
            bif.parallel_valid = (idx < 16);
            if (idx < 16) bif.parallel_data = tx[idx];
            bif.serial_ready = ($urandom_range(0, 3) != 0);
            fire_prev = bif.parallel_valid && bif.parallel_ready;
            cyc++;
        end
        bif.parallel_valid = 1'b0;
        bif.serial_ready   = 1'b1;
        chk("loop_word_count", 32'(rx_q.size()), 16);
        for (int i = 0; i < 16; i++) begin
            if (i < rx_q.size()) begin
                chk($sformatf("loop_word%0d", i), 32'(rx_q[i]), 32'(tx[i]));
                chk($sformatf("loop_align%0d", i), 32'(rx_cnt_q[i]), 7);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
